// File: rtl/dm_pkg.sv
// ----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder: FSM state encoding,
// access-op constants, default widths and the request-qualifier helper.
// Optional feature macro used by the users of this package: DM_PARITY_EN.
// ----------------------------------------------------------------------------
package dm_pkg;

  localparam int DM_DATA_BITS_DEF   = 32;
  localparam int DM_ADDR_BITS_DEF   = 12;
  localparam int DM_WAIT_STATES_DEF = 1;
  localparam int DM_CNT_BITS        = 4;   // holds WAIT_STATES-1 for 0..15

  typedef enum logic [1:0] {
    DM_IDLE = 2'b00,
    DM_WAIT = 2'b01,
    DM_DONE = 2'b10,
    DM_HOLD = 2'b11
  } dm_state_e;

  localparam logic DM_OP_READ  = 1'b0;
  localparam logic DM_OP_WRITE = 1'b1;

  // A request is only meaningful with exactly one of read/write set.
  function automatic logic dm_req_valid(input logic en, input logic rd, input logic wr);
    return en & (rd ^ wr);
  endfunction

endpackage

// File: rtl/dm_array.sv
// ----------------------------------------------------------------------------
// dm_array
// Synchronous single-port word array with write enable and a registered read
// port. The read register only updates on re_i, so it holds the last load.
// Optional feature: DM_PARITY_EN adds an even-parity bit per word, checked on
// read; perr_o is a one-cycle flag aligned with the read data update.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset (clears read register only)
//   we_i      in   write strobe
//   re_i      in   read strobe
//   addr_i    in   word address
//   wdata_i   in   write data
//   rdata_o   out  registered read data
//   perr_o    out  parity mismatch on the last read (0 without DM_PARITY_EN)
// ----------------------------------------------------------------------------
module dm_array
  import dm_pkg::*;
#(
  parameter int DATA_BITS = DM_DATA_BITS_DEF,
  parameter int ADDR_BITS = DM_ADDR_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 perr_o
);

`ifdef DM_PARITY_EN
  localparam int WORD_BITS = DATA_BITS + 1;   // parity in the MSB
`else
  localparam int WORD_BITS = DATA_BITS;
`endif

  logic [WORD_BITS-1:0] mem_q [2**ADDR_BITS];
  logic [WORD_BITS-1:0] wword_d;
  logic [WORD_BITS-1:0] rword_d;
  logic [DATA_BITS-1:0] rdata_q;
  logic                 perr_q;

  always_comb begin
`ifdef DM_PARITY_EN
    wword_d = {^wdata_i, wdata_i};
`else
    wword_d = wdata_i;
`endif
  end

  assign rword_d = mem_q[addr_i];

  // Contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wword_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (re_i) begin
        rdata_q <= rword_d[DATA_BITS-1:0];
`ifdef DM_PARITY_EN
        // Even parity: XOR over data plus stored parity is 0 for a clean word.
        perr_q  <= ^rword_d;
`endif
      end
    end
  end

  assign rdata_o = rdata_q;
  assign perr_o  = perr_q;

endmodule

// File: rtl/dm_responder.sv
// ----------------------------------------------------------------------------
// dm_responder
// Memory end of the DM bus. Samples the controller strobes into a request
// register, accepts one access at a time, inserts WAIT_STATES wait cycles and
// signals completion with a one-cycle DM_ready. Load data is registered and
// held until the next read completes.
// Optional feature macro: DM_PARITY_EN (per-word parity, DM_parity_error).
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous active-high reset
//   DM_enable        in   access request qualifier
//   DM_read          in   read request
//   DM_write         in   write request
//   DM_address       in   word address
//   DM_in            in   store data
//   DM_out           out  load data (registered)
//   DM_ready         out  one-cycle completion strobe
//   DM_parity_error  out  parity mismatch in the completing read cycle
//
// state | meaning
// IDLE  | waiting for a sampled request with exactly one of read/write
// WAIT  | counting down wait states on the latched request
// DONE  | access committed; DM_ready high for this cycle
// HOLD  | controller still holds DM_enable; wait for it to drop
// ----------------------------------------------------------------------------
module dm_responder
  import dm_pkg::*;
#(
  parameter int DATA_BITS   = DM_DATA_BITS_DEF,
  parameter int ADDR_BITS   = DM_ADDR_BITS_DEF,
  parameter int WAIT_STATES = DM_WAIT_STATES_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 DM_enable,
  input  logic                 DM_read,
  input  logic                 DM_write,
  input  logic [ADDR_BITS-1:0] DM_address,
  input  logic [DATA_BITS-1:0] DM_in,
  output logic [DATA_BITS-1:0] DM_out,
  output logic                 DM_ready,
  output logic                 DM_parity_error
);

  localparam logic [DM_CNT_BITS-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? DM_CNT_BITS'(WAIT_STATES - 1) : '0;

  dm_state_e state_q;
  logic [DM_CNT_BITS-1:0] cnt_q;
  logic                   ready_q;

  // Request sampling stage: the FSM accepts from these registers, which gives
  // the request-edge to DM_ready latency of WAIT_STATES+2 cycles.
  logic                 req_en_q;
  logic                 req_rd_q;
  logic                 req_wr_q;
  logic [ADDR_BITS-1:0] req_addr_q;
  logic [DATA_BITS-1:0] req_data_q;

  // Access latched at acceptance; used while in WAIT.
  logic                 op_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] data_q;

  logic                 req_ok_d;
  logic                 commit_d;
  logic                 op_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 we_d;
  logic                 re_d;

  always_comb begin
    req_ok_d = dm_req_valid(req_en_q, req_rd_q, req_wr_q);
    // With no wait states the array access happens on the accepting edge, so
    // the sampled request is used directly instead of the latched copy.
    if (state_q == DM_IDLE) begin
      op_d   = req_wr_q ? DM_OP_WRITE : DM_OP_READ;
      addr_d = req_addr_q;
      data_d = req_data_q;
    end else begin
      op_d   = op_q;
      addr_d = addr_q;
      data_d = data_q;
    end
    commit_d = ((state_q == DM_IDLE) && req_ok_d && (WAIT_STATES == 0)) ||
               ((state_q == DM_WAIT) && (cnt_q == '0));
    // Reset on the commit edge discards the pending write.
    we_d = commit_d && (op_d == DM_OP_WRITE) && !reset;
    re_d = commit_d && (op_d == DM_OP_READ);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= DM_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      req_en_q   <= 1'b0;
      req_rd_q   <= 1'b0;
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      op_q       <= DM_OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      req_en_q   <= DM_enable;
      req_rd_q   <= DM_read;
      req_wr_q   <= DM_write;
      req_addr_q <= DM_address;
      req_data_q <= DM_in;
      ready_q    <= 1'b0;
      unique case (state_q)
        DM_IDLE: begin
          if (req_ok_d) begin
            op_q   <= op_d;
            addr_q <= req_addr_q;
            data_q <= req_data_q;
            if (WAIT_STATES > 0) begin
              state_q <= DM_WAIT;
              cnt_q   <= WAIT_LOAD;
            end else begin
              state_q <= DM_DONE;
              ready_q <= 1'b1;
            end
          end
        end
        DM_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DM_DONE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DM_DONE: begin
          state_q <= DM_enable ? DM_HOLD : DM_IDLE;
        end
        DM_HOLD: begin
          if (!DM_enable) begin
            state_q <= DM_IDLE;
          end
        end
        default: state_q <= DM_IDLE;
      endcase
    end
  end

  dm_array #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .we_i   (we_d),
    .re_i   (re_d),
    .addr_i (addr_d),
    .wdata_i(data_d),
    .rdata_o(DM_out),
    .perr_o (DM_parity_error)
  );

  assign DM_ready = ready_q;

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder on the CPU side of the DM bus: the memory end answering the controller's `DM_enable`/`DM_read`/`DM_write` strobes. It holds a word-addressed storage array and serves one access at a time through a small state machine with programmable wait states and a completion strobe. It sits between the datapath (address/store data) and the writeback mux (load data), beside the instruction memory.

## Interface
Parameters:
- `DATA_BITS`, 32, word width.
- `ADDR_BITS`, 12, word-address width; array depth is 2^ADDR_BITS words.
- `WAIT_STATES`, 1, extra cycles inserted before completion; legal range 0..15.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `DM_enable`  in  1  access request qualifier.
- `DM_read`  in  1  read request (valid with `DM_enable`).
- `DM_write`  in  1  write request (valid with `DM_enable`).
- `DM_address`  in  ADDR_BITS  word address.
- `DM_in`  in  DATA_BITS  store data.
- `DM_out`  out  DATA_BITS  load data, registered.
- `DM_ready`  out  1  one-cycle completion strobe.
- `DM_parity_error`  out  1  parity mismatch on the completing read (see Configuration).

## Operation
- States: IDLE, WAIT, DONE, HOLD.
- IDLE: a request is accepted when `DM_enable`=1 and exactly one of `DM_read`/`DM_write` is 1. Address, store data and op are latched at the accepting edge. If both or neither are set, no request is accepted and the state stays IDLE.
- After accepting: go to WAIT if `WAIT_STATES`>0 (counter loaded with `WAIT_STATES`-1), else go straight to DONE.
- WAIT: the counter decrements each cycle. Go to DONE on the edge where the counter is 0. Inputs are ignored in WAIT; the latched values are used.
- Entering DONE edge:
  - A write commits the latched data to the array.
  - A read loads `DM_out` from the array.
- DONE:
  - `DM_ready`=1 for exactly this cycle.
  - Next state is HOLD if `DM_enable` is still 1, else IDLE.
- HOLD: go to IDLE on the first cycle with `DM_enable`=0. This prevents re-executing a strobe the controller holds across states.
- `DM_out` holds its value until the next read completes; writes do not change it.
- A write followed by a read of the same address returns the new data.

## Timing
- Reset values:
  - state IDLE, wait counter 0.
  - `DM_ready`=0, `DM_out`=0, `DM_parity_error`=0.
  - Array contents are not cleared.
- Latency: request sampled at edge k → `DM_ready` high in the cycle after edge k+1+WAIT_STATES. Read data is valid in that same cycle.
- Reset mid-operation (in WAIT, or at the same edge as the DONE entry): the pending write is discarded, `DM_out` goes to 0, and the state returns to IDLE.
- Address wrap: not applicable; every ADDR_BITS value is a valid index.
- Minimum spacing between accepted requests: WAIT_STATES+2 cycles, plus any HOLD cycles.

## Configuration
- `DM_PARITY_EN` defined:
  - Each array word stores an extra even-parity bit computed on write.
  - A completing read recomputes parity and drives `DM_parity_error`=1 in the DONE cycle on mismatch; it is 0 in all other cycles.
- `DM_PARITY_EN` undefined: there is no parity storage and `DM_parity_error` is tied 0.

## Structure
- Shared package `dm_pkg`:
  - state encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10, HOLD=2'b11).
  - `DM_OP_READ`/`DM_OP_WRITE` constants.
  - default widths.
- Sub-module `dm_array`: a synchronous single-port array with write enable, registered read, and the optional parity bit. The FSM, counter and latches live in `dm_responder`.

## Test plan
- Reset, then `WAIT_STATES`=1: write 0xDEADBEEF to address 0x010 → `DM_ready` pulses 3 cycles after the request edge. A subsequent read of 0x010 → `DM_out`=0xDEADBEEF with `DM_ready`.
- `WAIT_STATES`=0: read request → `DM_ready` in the cycle after the next edge. `DM_enable` held high 4 more cycles → no second `DM_ready` (HOLD); drop `DM_enable` → IDLE.
- `DM_read`=`DM_write`=1 with `DM_enable`=1 for 5 cycles → no `DM_ready`, array unchanged, `DM_out` unchanged.
- Write 0x12345678 to 0x020, assert `reset` during WAIT → no `DM_ready`. A later read of 0x020 returns the prior contents (pre-written 0x0), not 0x12345678.
- With `DM_PARITY_EN`: write 0x00000001, force-flip the stored data bit 0 via hierarchical access, read → `DM_parity_error`=1 only in the DONE cycle. A clean word reads with error 0.
